// File: rtl/hyperbus_rxbuf_pkg.sv
// -----------------------------------------------------------------------------
// hyperbus_rxbuf_pkg
// Shared HyperBus constants: default DQ width and the receive-buffer FSM state
// encodings used by hyperbus_rxbuf.
// -----------------------------------------------------------------------------
package hyperbus_rxbuf_pkg;

    // Default HyperBus DQ width; a captured word is two DQ beats wide.
    localparam int unsigned HB_DEFAULT_WIDTH = 8;

    // Receive-buffer FSM encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/hyperbus_fifo.sv
// -----------------------------------------------------------------------------
// hyperbus_fifo
// Synchronous FIFO with wrap-bit pointers. A push is taken when not full, or
// when full with a simultaneous pop. A pop is taken only when not empty, so a
// push into an empty FIFO is visible at rdata/!empty one cycle later.
//
// Ports:
//   clk90  in   clock, rising edge
//   rst    in   asynchronous active-high reset (pointers only)
//   push   in   write request, wdata is written if accepted
//   wdata  in   WIDTH-bit write data
//   pop    in   read request, head advances if not empty
//   rdata  out  WIDTH-bit head-of-FIFO word (undefined while empty)
//   full   out  FIFO holds DEPTH words
//   empty  out  FIFO holds no words
// -----------------------------------------------------------------------------
module hyperbus_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk90,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    // Full when only the wrap bits differ; empty when pointers match exactly.
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty = (r_wptr == r_rptr);

    assign w_rd  = pop & ~empty;
    // When full, a concurrent pop frees the slot the push lands in.
    assign w_wr  = push & (~full | w_rd);

    assign rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk90) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hyperbus_rxbuf.sv
// -----------------------------------------------------------------------------
// hyperbus_rxbuf
// HyperBus read receive buffer. A start request launches a burst of len_i
// words: rrq is raised while words are captured from the controller into a
// FIFO, then the block waits for the consumer to drain the FIFO and pulses
// done. Words arriving while the FIFO is full (and not being popped) are
// dropped and flagged on the sticky overflow output.
//
// Ports:
//   clk90       in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   single-cycle burst request (honoured only when idle)
//   len_i       in   burst length in words, sampled with start
//   rrq         out  read request, high during capture
//   in_dat      in   2*WIDTH-bit read word from the controller
//   in_valid    in   in_dat valid (cannot be stalled)
//   out_dat     out  head-of-FIFO word
//   out_valid   out  FIFO not empty
//   out_ready   in   consumer accepts out_dat
//   busy        out  FSM not idle
//   done        out  one-cycle burst completion pulse
//   overflow    out  sticky: a word was dropped
//   words_left  out  words still to capture
// -----------------------------------------------------------------------------
module hyperbus_rxbuf
    import hyperbus_rxbuf_pkg::*;
#(
    parameter int WIDTH     = HB_DEFAULT_WIDTH,
    parameter int DEPTH     = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk90,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 rrq,
    input  logic [2*WIDTH-1:0]   in_dat,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   out_dat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [LEN_WIDTH-1:0] words_left
);

    logic [1:0]           r_state;
    logic [LEN_WIDTH-1:0] r_words_left;
    logic                 r_overflow;
    logic                 r_done_zero;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_cap_push;
    logic                 w_drop;

    assign w_pop      = ~w_empty & out_ready;
    assign w_cap_push = (r_state == ST_CAPTURE) & in_valid;
    assign w_drop     = w_cap_push & w_full & ~w_pop;

    hyperbus_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk90 (clk90),
        .rst   (rst),
        .push  (w_cap_push),
        .wdata (in_dat),
        .pop   (w_pop),
        .rdata (out_dat),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_words_left <= '0;
            r_overflow   <= 1'b0;
            r_done_zero  <= 1'b0;
        end else begin
            r_done_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_i != '0) begin
                            r_words_left <= len_i;
                            r_overflow   <= 1'b0;
                            r_state      <= ST_CAPTURE;
                        end else begin
                            // Zero-length burst completes without a request.
                            r_done_zero <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (in_valid) begin
                        if (w_drop) r_overflow <= 1'b1;
                        // Dropped words still count against the burst.
                        if (r_words_left != '0) r_words_left <= r_words_left - 1'b1;
                        if (r_words_left <= LEN_WIDTH'(1)) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // rrq/busy decode registered state, so reset removes them asynchronously.
    assign rrq        = (r_state == ST_CAPTURE);
    assign busy       = (r_state != ST_IDLE);
    // The drain-complete pulse is the cycle in which DRAIN sees an empty FIFO.
    assign done       = r_done_zero | ((r_state == ST_DRAIN) & w_empty);
    assign overflow   = r_overflow;
    assign words_left = r_words_left;
    assign out_valid  = ~w_empty;

endmodule

// File: tb/tb_hyperbus_rxbuf.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_rxbuf
// Directed and randomized stimulus for hyperbus_rxbuf, checked each cycle
// against a queue-based behavioural model of the burst/FIFO rules.
// -----------------------------------------------------------------------------
module tb_hyperbus_rxbuf;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int LW    = 8;

    localparam int P_IDLE  = 0;
    localparam int P_CAP   = 1;
    localparam int P_DRAIN = 2;

    logic            clk90 = 1'b0;
    logic            rst;
    logic            start;
    logic [LW-1:0]   len_i;
    logic            rrq;
    logic [15:0]     in_dat;
    logic            in_valid;
    logic [15:0]     out_dat;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [LW-1:0]   words_left;

    int errors = 0;
    int checks = 0;

    // Behavioural model
    int          m_phase;
    logic [15:0] m_q[$];
    int          m_left;
    logic        m_ovf;
    logic        m_zero_done;
    logic [15:0] poplog[$];

    always #5 clk90 = ~clk90;

    hyperbus_rxbuf #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .LEN_WIDTH (LW)
    ) dut (
        .clk90      (clk90),
        .rst        (rst),
        .start      (start),
        .len_i      (len_i),
        .rrq        (rrq),
        .in_dat     (in_dat),
        .in_valid   (in_valid),
        .out_dat    (out_dat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .words_left (words_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = P_IDLE;
        m_q.delete();
        m_left      = 0;
        m_ovf       = 1'b0;
        m_zero_done = 1'b0;
    endtask

    task automatic check_outputs();
        chk("rrq",        32'(rrq),        32'(m_phase == P_CAP));
        chk("busy",       32'(busy),       32'(m_phase != P_IDLE));
        chk("done",       32'(done),       32'(m_zero_done || (m_phase == P_DRAIN && m_q.size() == 0)));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("words_left", 32'(words_left), 32'(m_left));
        chk("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_dat", 32'(out_dat), 32'(m_q[0]));
    endtask

    // Called at a falling edge: check current outputs, drive inputs for the
    // next rising edge, advance the model, move to the next falling edge.
    task automatic step(input logic s, input logic [LW-1:0] l, input logic iv,
                        input logic [15:0] d, input logic ordy);
        logic pop;
        logic pre_empty;
        logic accept;
        logic nzero;
        check_outputs();
        start     = s;
        len_i     = l;
        in_valid  = iv;
        in_dat    = d;
        out_ready = ordy;

        pre_empty = (m_q.size() == 0);
        pop       = !pre_empty && ordy;
        accept    = (m_phase == P_CAP) && iv && (m_q.size() < DEPTH || pop);
        nzero     = 1'b0;
        if (pop) poplog.push_back(out_dat);

        case (m_phase)
            P_IDLE: begin
                if (s) begin
                    if (l != 0) begin
                        m_left  = int'(l);
                        m_ovf   = 1'b0;
                        m_phase = P_CAP;
                    end else begin
                        nzero = 1'b1;
                    end
                end
            end
            P_CAP: begin
                if (iv) begin
                    if (!accept) m_ovf = 1'b1;
                    if (m_left > 0) m_left--;
                    if (m_left == 0) m_phase = P_DRAIN;
                end
            end
            default: begin
                if (pre_empty) m_phase = P_IDLE;
            end
        endcase
        if (pop) void'(m_q.pop_front());
        if (accept) m_q.push_back(d);
        m_zero_done = nzero;
        @(negedge clk90);
    endtask

    task automatic wait_idle(input logic ordy, input int maxc);
        int n;
        n = 0;
        while ((m_phase != P_IDLE || m_zero_done) && n < maxc) begin
            step(1'b0, '0, 1'($urandom_range(0, 1)), 16'($urandom), ordy);
            n++;
        end
        chk("idle_reached", 32'(n < maxc), 32'd1);
        chk("busy_after_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp4 [4];
        exp4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        rst = 1'b1; start = 1'b0; len_i = '0; in_valid = 1'b0;
        in_dat = '0; out_ready = 1'b0;
        model_reset();

        // Reset state while rst is held
        #2;
        check_outputs();
        @(negedge clk90);
        rst = 1'b0;

        // Basic burst of four, consumer always ready
        poplog.delete();
        step(1'b1, 8'd4, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, exp4[i], 1'b1);
        wait_idle(1'b1, 20);
        chk("t1_pop_count", 32'(poplog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (poplog.size() > i) chk("t1_order", 32'(poplog[i]), 32'(exp4[i]));

        // Overflow: ten words into eight entries with no consumer
        poplog.delete();
        step(1'b1, 8'd10, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 16'hA000 + 16'(i), 1'b0);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_words_left", 32'(words_left), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 16'hEEEE, 1'b0);
        chk("t2_drain_hold", 32'(busy), 32'd1);
        wait_idle(1'b1, 40);
        chk("t2_pop_count", 32'(poplog.size()), 32'd8);
        if (poplog.size() == 8) chk("t2_last_word", 32'(poplog[7]), 32'hA007);

        // Full FIFO with simultaneous push and pop
        poplog.delete();
        step(1'b1, 8'd9, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 16'hB000 + 16'(i), 1'b0);
        step(1'b0, '0, 1'b1, 16'hB008, 1'b1);
        chk("t3_no_overflow", 32'(overflow), 32'd0);
        wait_idle(1'b1, 40);
        chk("t3_pop_count", 32'(poplog.size()), 32'd9);
        if (poplog.size() == 9) chk("t3_last_word", 32'(poplog[8]), 32'hB008);

        // Zero-length start
        step(1'b1, 8'd0, 1'b0, 16'h0, 1'b0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_rrq", 32'(rrq), 32'd0);
        step(1'b0, '0, 1'b1, 16'h5555, 1'b0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Reset mid-burst, then a one-word burst straight after release
        step(1'b1, 8'd6, 1'b0, 16'h0, 1'b0);
        step(1'b0, '0, 1'b1, 16'hC000, 1'b0);
        step(1'b0, '0, 1'b1, 16'hC001, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rrq_async", 32'(rrq), 32'd0);
        chk("t5_out_valid_async", 32'(out_valid), 32'd0);
        chk("t5_words_left_async", 32'(words_left), 32'd0);
        model_reset();
        @(negedge clk90);
        rst = 1'b0;
        poplog.delete();
        step(1'b1, 8'd1, 1'b0, 16'h0, 1'b1);
        step(1'b0, '0, 1'b1, 16'hC0DE, 1'b1);
        wait_idle(1'b1, 10);
        chk("t5_pop_count", 32'(poplog.size()), 32'd1);
        if (poplog.size() == 1) chk("t5_word", 32'(poplog[0]), 32'hC0DE);

        // Start during capture is ignored
        step(1'b1, 8'd5, 1'b0, 16'h0, 1'b1);
        step(1'b0, '0, 1'b1, 16'hD001, 1'b1);
        step(1'b1, 8'd2, 1'b1, 16'hD002, 1'b1);
        chk("t6_words_left", 32'(words_left), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 16'hD003 + 16'(i), 1'b1);
        wait_idle(1'b1, 20);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 12)),
                 1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 3) != 0));
        wait_idle(1'b1, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
